// File: rtl/time_keeper.sv
// Timekeeping core: divides CLK to one-second ticks and keeps h:mm:ss AM/PM.
// A two-switch set mode adjusts hour and minute; outputs are all registered.
module time_keeper #(
  parameter int unsigned TICKS_PER_SEC = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TIMESET_RUN,
  input  logic       SW_F1,
  input  logic       SW_F2,
  output logic       AMPM,
  output logic [3:0] HOUR,
  output logic [2:0] MINHIGH,
  output logic [3:0] MINLOW,
  output logic [2:0] SECHIGH,
  output logic [3:0] SECLOW,
  output logic       SEC_TICK,
  output logic       MIN_TICK,
  output logic       SET_FIELD
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM_CNT = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_e;

  // Bit 0 = TIMESET_RUN, bit 1 = SW_F1, bit 2 = SW_F2.
  logic [2:0] raw_in;
  logic [2:0] sync1_q, sync2_q, dly_q;
  logic [2:0] rise;
  logic       ts_lvl, f1_rise, f2_rise;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ampm_q, ampm_d;
  logic [3:0]    hour_q, hour_d;
  logic [2:0]    minh_q, minh_d;
  logic [3:0]    minl_q, minl_d;
  logic [2:0]    sech_q, sech_d;
  logic [3:0]    secl_q, secl_d;
  logic          sec_tick_q, sec_tick_d;
  logic          min_tick_q, min_tick_d;
  logic          set_field_q, set_field_d;

  logic          min_carry, min_step, hour_step, min_wrap;

  assign raw_in  = {SW_F2, SW_F1, TIMESET_RUN};
  assign rise    = sync2_q & ~dly_q;
  assign ts_lvl  = sync2_q[0];
  assign f1_rise = rise[1];
  assign f2_rise = rise[2];

  // Two-stage synchronizer followed by an edge-detect delay stage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= RUN;
      presc_q     <= '0;
      ampm_q      <= 1'b0;
      hour_q      <= '0;
      minh_q      <= '0;
      minl_q      <= '0;
      sech_q      <= '0;
      secl_q      <= '0;
      sec_tick_q  <= 1'b0;
      min_tick_q  <= 1'b0;
      set_field_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ampm_q      <= ampm_d;
      hour_q      <= hour_d;
      minh_q      <= minh_d;
      minl_q      <= minl_d;
      sech_q      <= sech_d;
      secl_q      <= secl_d;
      sec_tick_q  <= sec_tick_d;
      min_tick_q  <= min_tick_d;
      set_field_q <= set_field_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    ampm_d     = ampm_q;
    hour_d     = hour_q;
    minh_d     = minh_q;
    minl_d     = minl_q;
    sech_d     = sech_q;
    secl_d     = secl_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    min_carry  = 1'b0;
    min_step   = 1'b0;
    hour_step  = 1'b0;
    min_wrap   = 1'b0;

    case (state_q)
      RUN: begin
        // Entering set mode takes priority over a coincident terminal count.
        if (ts_lvl) begin
          state_d = SET_HOUR;
          presc_d = '0;
          sech_d  = '0;
          secl_d  = '0;
        end else if (presc_q == TERM_CNT) begin
          presc_d    = '0;
          sec_tick_d = 1'b1;
          if (secl_q >= 4'd9) begin
            secl_d = '0;
            if (sech_q >= 3'd5) begin
              sech_d    = '0;
              min_carry = 1'b1;
            end else begin
              sech_d = sech_q + 3'd1;
            end
          end else begin
            secl_d = secl_q + 4'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      SET_HOUR, SET_MIN: begin
        presc_d = '0;
        sech_d  = '0;
        secl_d  = '0;
        if (!ts_lvl) begin
          state_d = RUN;
        end else begin
          if (f2_rise) begin
            if (state_q == SET_HOUR) hour_step = 1'b1;
            else                     min_step  = 1'b1;
          end
          if (f1_rise) state_d = (state_q == SET_HOUR) ? SET_MIN : SET_HOUR;
        end
      end
      default: begin
        state_d = RUN;
        presc_d = '0;
      end
    endcase

    // Minute increment; only a run-mode carry propagates into the hour.
    if (min_carry || min_step) begin
      if (minl_q >= 4'd9) begin
        minl_d = '0;
        if (minh_q >= 3'd5) begin
          minh_d   = '0;
          min_wrap = 1'b1;
        end else begin
          minh_d = minh_q + 3'd1;
        end
      end else begin
        minl_d = minl_q + 4'd1;
      end
    end
    min_tick_d = min_carry;
    if (min_carry && min_wrap) hour_step = 1'b1;

    if (hour_step) begin
      if (hour_q >= 4'd11) begin
        hour_d = '0;
        ampm_d = ~ampm_q;
      end else begin
        hour_d = hour_q + 4'd1;
      end
    end

    set_field_d = (state_d == SET_MIN);
  end

  assign AMPM      = ampm_q;
  assign HOUR      = hour_q;
  assign MINHIGH   = minh_q;
  assign MINLOW    = minl_q;
  assign SECHIGH   = sech_q;
  assign SECLOW    = secl_q;
  assign SEC_TICK  = sec_tick_q;
  assign MIN_TICK  = min_tick_q;
  assign SET_FIELD = set_field_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed table, hand sequences and random stimulus,
// all compared cycle by cycle against a minute-of-day reference model.
module tb_time_keeper;

  localparam int unsigned TPS = 4;

  logic       CLK;
  logic       RST;
  logic       TIMESET_RUN, SW_F1, SW_F2;
  logic       AMPM;
  logic [3:0] HOUR;
  logic [2:0] MINHIGH;
  logic [3:0] MINLOW;
  logic [2:0] SECHIGH;
  logic [3:0] SECLOW;
  logic       SEC_TICK, MIN_TICK, SET_FIELD;

  time_keeper #(.TICKS_PER_SEC(TPS)) dut (
    .CLK(CLK), .RST(RST), .TIMESET_RUN(TIMESET_RUN), .SW_F1(SW_F1), .SW_F2(SW_F2),
    .AMPM(AMPM), .HOUR(HOUR), .MINHIGH(MINHIGH), .MINLOW(MINLOW),
    .SECHIGH(SECHIGH), .SECLOW(SECLOW), .SEC_TICK(SEC_TICK), .MIN_TICK(MIN_TICK),
    .SET_FIELD(SET_FIELD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;
  int st_total = 0;
  int mt_total = 0;

  // Reference model: time kept as minute-of-day plus seconds.
  localparam int M_RUN = 0, M_SH = 1, M_SM = 2;
  int   m_mod, m_sec, m_cnt, m_mode;
  bit   m_st, m_mt, m_fld;
  bit [3:0] h_ts, h_f1, h_f2;

  task automatic model_reset();
    m_mod = 0; m_sec = 0; m_cnt = 0; m_mode = M_RUN;
    m_st = 0; m_mt = 0; m_fld = 0;
    h_ts = '0; h_f1 = '0; h_f2 = '0;
  endtask

  task automatic model_edge(input bit ts, input bit f1, input bit f2);
    bit lvl, r1, r2;
    h_ts = {h_ts[2:0], ts};
    h_f1 = {h_f1[2:0], f1};
    h_f2 = {h_f2[2:0], f2};
    lvl = h_ts[2];
    r1  = h_f1[2] & ~h_f1[3];
    r2  = h_f2[2] & ~h_f2[3];
    m_st = 0;
    m_mt = 0;
    if (m_mode == M_RUN) begin
      if (lvl) begin
        m_mode = M_SH; m_cnt = 0; m_sec = 0;
      end else begin
        m_cnt++;
        if (m_cnt == TPS) begin
          m_cnt = 0; m_st = 1; m_sec++;
          if (m_sec == 60) begin
            m_sec = 0; m_mt = 1; m_mod = (m_mod + 1) % 1440;
          end
        end
      end
    end else begin
      if (!lvl) begin
        m_mode = M_RUN; m_cnt = 0;
      end else begin
        if (r2) begin
          if (m_mode == M_SH) m_mod = (m_mod + 60) % 1440;
          else                m_mod = (m_mod / 60) * 60 + ((m_mod % 60) + 1) % 60;
        end
        if (r1) m_mode = (m_mode == M_SH) ? M_SM : M_SH;
      end
    end
    m_fld = (m_mode == M_SM);
  endtask

  function automatic logic [21:0] model_vec();
    return {1'(m_mod >= 720), 4'((m_mod / 60) % 12), 3'((m_mod % 60) / 10),
            4'(m_mod % 10), 3'(m_sec / 10), 4'(m_sec % 10), m_st, m_mt, m_fld};
  endfunction

  logic [21:0] dut_vec;
  assign dut_vec = {AMPM, HOUR, MINHIGH, MINLOW, SECHIGH, SECLOW, SEC_TICK, MIN_TICK, SET_FIELD};

  task automatic check_cycle();
    logic [21:0] exp_v;
    exp_v = model_vec();
    n_vec++;
    if (dut_vec !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_vs_model t=%0t: got %h, expected %h", $time, dut_vec, exp_v);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_edge(TIMESET_RUN, SW_F1, SW_F2);
    #1;
    if (SEC_TICK) st_total++;
    if (MIN_TICK) mt_total++;
    check_cycle();
  endtask

  function automatic int dut_min();
    return int'(MINHIGH) * 10 + int'(MINLOW);
  endfunction

  function automatic int dut_sec();
    return int'(SECHIGH) * 10 + int'(SECLOW);
  endfunction

  task automatic do_reset();
    RST = 1'b0; TIMESET_RUN = 1'b0; SW_F1 = 1'b0; SW_F2 = 1'b0;
    model_reset();
    #1;
    check_val("reset_outputs", int'(dut_vec), 0);
    tick();
    RST = 1'b1;
  endtask

  task automatic pulse_f2(input int n);
    repeat (n) begin
      SW_F2 = 1'b1; tick();
      SW_F2 = 1'b0; tick();
    end
    repeat (3) tick();
  endtask

  task automatic pulse_f1();
    SW_F1 = 1'b1; tick();
    SW_F1 = 1'b0; repeat (3) tick();
  endtask

  task automatic enter_set();
    TIMESET_RUN = 1'b1; repeat (3) tick();
  endtask

  task automatic exit_set();
    TIMESET_RUN = 1'b0; repeat (3) tick();
  endtask

  typedef struct {
    bit ts; bit f1; bit f2; int n;
    bit chk; int hour; int ampm; int minute; int field;
  } vec_t;

  vec_t tbl[24];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first, st0, mt0;

    tbl[0]  = '{1,0,0,3, 1,0,0,0,0};
    tbl[1]  = '{1,0,1,1, 0,0,0,0,0};
    tbl[2]  = '{1,0,0,1, 0,0,0,0,0};
    tbl[3]  = '{1,0,1,1, 0,0,0,0,0};
    tbl[4]  = '{1,0,0,1, 0,0,0,0,0};
    tbl[5]  = '{1,0,1,1, 0,0,0,0,0};
    tbl[6]  = '{1,0,0,3, 1,3,0,0,0};
    tbl[7]  = '{1,1,0,1, 0,0,0,0,0};
    tbl[8]  = '{1,0,0,3, 1,3,0,0,1};
    tbl[9]  = '{1,0,1,1, 0,0,0,0,0};
    tbl[10] = '{1,0,0,3, 1,3,0,1,1};
    tbl[11] = '{1,1,0,1, 0,0,0,0,0};
    tbl[12] = '{1,0,0,3, 1,3,0,1,0};
    tbl[13] = '{1,0,1,1, 0,0,0,0,0};
    tbl[14] = '{1,0,0,1, 0,0,0,0,0};
    tbl[15] = '{1,0,1,1, 0,0,0,0,0};
    tbl[16] = '{1,0,0,3, 1,5,0,1,0};
    tbl[17] = '{1,1,1,1, 0,0,0,0,0};
    tbl[18] = '{1,0,0,3, 1,6,0,1,1};
    tbl[19] = '{1,0,1,20,0,0,0,0,0};
    tbl[20] = '{1,0,0,3, 1,6,0,2,1};
    tbl[21] = '{0,0,0,3, 1,6,0,2,0};
    tbl[22] = '{0,1,1,5, 0,0,0,0,0};
    tbl[23] = '{0,0,0,3, 1,6,0,2,0};

    // Minute carry from reset.
    do_reset();
    first = -1; st0 = st_total; mt0 = mt_total;
    for (int i = 1; i <= 240; i++) begin
      tick();
      if (SEC_TICK && first < 0) first = i;
    end
    check_val("s1_sec_ticks", st_total - st0, 60);
    check_val("s1_min_ticks", mt_total - mt0, 1);
    check_val("s1_first_tick", first, 4);
    check_val("s1_minutes", dut_min(), 1);
    check_val("s1_seconds", dut_sec(), 0);

    // Set entry coinciding with terminal count, then hour wrap into PM.
    do_reset();
    tick();
    TIMESET_RUN = 1'b1;
    repeat (3) tick();
    check_val("tc_vs_set_tick", int'(SEC_TICK), 0);
    check_val("tc_vs_set_secs", dut_sec(), 0);
    pulse_f2(11);
    check_val("s2_hour11", int'(HOUR), 11);
    pulse_f1();
    pulse_f2(59);
    check_val("s2_min59", dut_min(), 59);
    exit_set();
    repeat (240) tick();
    check_val("s2_hour", int'(HOUR), 0);
    check_val("s2_ampm", int'(AMPM), 1);
    check_val("s2_minutes", dut_min(), 0);

    // Table: field select, simultaneous edges, held switch, run-mode ignore.
    do_reset();
    foreach (tbl[i]) begin
      TIMESET_RUN = tbl[i].ts; SW_F1 = tbl[i].f1; SW_F2 = tbl[i].f2;
      repeat (tbl[i].n) tick();
      if (tbl[i].chk) begin
        check_val($sformatf("tbl%0d_hour", i), int'(HOUR), tbl[i].hour);
        check_val($sformatf("tbl%0d_ampm", i), int'(AMPM), tbl[i].ampm);
        check_val($sformatf("tbl%0d_min", i), dut_min(), tbl[i].minute);
        check_val($sformatf("tbl%0d_field", i), int'(SET_FIELD), tbl[i].field);
      end
    end

    // Minute wrap in set mode without hour carry or MIN_TICK.
    do_reset();
    enter_set();
    pulse_f2(3);
    pulse_f1();
    mt0 = mt_total;
    pulse_f2(61);
    check_val("s3_minutes", dut_min(), 1);
    check_val("s3_hour", int'(HOUR), 3);
    check_val("s3_field", int'(SET_FIELD), 1);
    check_val("s3_no_min_tick", mt_total - mt0, 0);

    // Asynchronous reset in SET_MIN at 7:42 PM.
    do_reset();
    enter_set();
    pulse_f2(19);
    pulse_f1();
    pulse_f2(42);
    check_val("s6_hour", int'(HOUR), 7);
    check_val("s6_ampm", int'(AMPM), 1);
    check_val("s6_min", dut_min(), 42);
    #2;
    RST = 1'b0; TIMESET_RUN = 1'b0; SW_F1 = 1'b0; SW_F2 = 1'b0;
    model_reset();
    #1;
    check_val("s6_async_clear", int'(dut_vec), 0);
    tick(); tick();
    RST = 1'b1;
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (SEC_TICK && first < 0) first = i;
    end
    check_val("s6_first_tick", first, 4);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        #2;
        do_reset();
      end else begin
        if ($urandom_range(0, 39) == 0) TIMESET_RUN = ~TIMESET_RUN;
        if ($urandom_range(0, 2) == 0) SW_F1 = ~SW_F1;
        if ($urandom_range(0, 1) == 0) SW_F2 = ~SW_F2;
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Timekeeping core for the digital clock: divides the system clock to one-second ticks and maintains seconds, minutes, hour and AM/PM. It is the producer of the AMPM/HOUR/MINHIGH/MINLOW time bus that the alarm block compares against. A two-switch set mode, mirroring the alarm-set controls, lets the user adjust hour and minute. Only one of the two modes is active at a time.

## Interface
- TICKS_PER_SEC, 1000, CLK cycles per second. Must be ≥ 2. Prescaler width is $clog2(TICKS_PER_SEC).
- CLK  in  1  system clock; every register updates on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- TIMESET_RUN  in  1  1 = set mode, 0 = run mode. Raw level.
- SW_F1  in  1  field-select switch. Raw level.
- SW_F2  in  1  increment switch. Raw level.
- AMPM  out  1  0 = AM, 1 = PM.
- HOUR  out  4  0..11.
- MINHIGH  out  3  minute tens, 0..5.
- MINLOW  out  4  minute units, 0..9.
- SECHIGH  out  3  second tens, 0..5.
- SECLOW  out  4  second units, 0..9.
- SEC_TICK  out  1  one-cycle pulse when the seconds value advances in run mode.
- MIN_TICK  out  1  one-cycle pulse when the minutes value advances by carry in run mode.
- SET_FIELD  out  1  in set mode: 0 = hour field selected, 1 = minute field selected. Forced to 0 in run mode.

## Operation
- **Input conditioning.** TIMESET_RUN, SW_F1 and SW_F2 each pass through a 2-FF synchronizer and then a delay register. The conditioned level is the second synchronizer stage. A rising edge is the second stage = 1 while the delay register = 0.
- **Reset.** All outputs are 0: time 0:00:00 AM, SEC_TICK = 0, MIN_TICK = 0, SET_FIELD = 0. Prescaler = 0, state = RUN, synchronizers cleared.
- **State machine:** states RUN, SET_HOUR, SET_MIN.
  - RUN → SET_HOUR when the conditioned TIMESET_RUN = 1. On this transition the prescaler and both seconds digits clear.
  - SET_HOUR ↔ SET_MIN on each SW_F1 rising edge.
  - SET_HOUR or SET_MIN → RUN when the conditioned TIMESET_RUN = 0. The prescaler restarts from 0.
- **Run mode.**
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - At terminal count: SEC_TICK pulses and the seconds value increments. 59 → 00 carries into minutes.
  - Minutes 59 → 00 carries into hour. MIN_TICK pulses on every minute carry.
  - Hour 11 → 0 toggles AMPM.
  - SW_F1 and SW_F2 edges are ignored.
- **Set mode.**
  - Prescaler and seconds are held at 0. SEC_TICK = 0 and MIN_TICK = 0.
  - SW_F2 rising edge in SET_HOUR: hour increments; 11 → 0 toggles AMPM, so all 24 hours are reachable.
  - SW_F2 rising edge in SET_MIN: minute increments; 59 → 00 wraps with no carry into hour.
- **Held switch.** A switch held at 1 produces exactly one edge, hence exactly one action.
- **Simultaneous edges.** If SW_F1 and SW_F2 edges occur in the same cycle, the increment applies to the currently selected field and the field toggles at the same clock edge.
- **Mode change vs. tick.** If the conditioned TIMESET_RUN rises in the same cycle as the prescaler terminal count, set mode wins: no SEC_TICK and no increment.
- **Digit invariant.** Digit outputs never leave their legal ranges. Each digit wraps independently at its limit.

## Timing
- **Switch-to-output latency.** An input change sampled at rising edge k updates the affected registered output at edge k+2. This applies to time digits, SET_FIELD and the state.
- **Tick spacing.** In run mode SEC_TICK is high for exactly 1 cycle every TICKS_PER_SEC cycles. The first SEC_TICK after reset release or set-mode exit occurs TICKS_PER_SEC cycles after the prescaler starts from 0.
- **Tick alignment.** SEC_TICK and MIN_TICK are registered and coincide with the cycle in which the new digit values are first visible.
- **Output glitches.** All outputs are registered; there are no combinational paths from inputs to outputs.
- **Reset mid-operation.** Asserting RST at any point, including mid-set, clears everything immediately (asynchronously). After RST release, operation resumes in RUN from 0:00:00 AM.

## Test plan
All scenarios use TICKS_PER_SEC = 4.

1. **Minute carry.** Release reset and run 240 cycles → MINLOW = 1, seconds = 00. SEC_TICK has pulsed 60 times and MIN_TICK exactly once.
2. **Hour wrap and AM/PM.** Set mode, SW_F2 ×11 (HOUR = 11), SW_F1, SW_F2 ×59 (minutes 59), exit set, run 240 cycles → HOUR = 0, AMPM = 1, MINHIGH = 0, MINLOW = 0.
3. **Field select and minute wrap.** Set mode, SW_F2 ×3 → HOUR = 3, SET_FIELD = 0. Then SW_F1, SW_F2 ×61 → minutes = 01, HOUR = 3, SET_FIELD = 1. No MIN_TICK during set.
4. **Simultaneous edges.** In SET_HOUR at HOUR = 5, raise SW_F1 and SW_F2 in the same cycle → two cycles later HOUR = 6 and SET_FIELD = 1.
5. **Held switch and run-mode ignore.** Hold SW_F2 high for 20 cycles in set mode → exactly +1. Toggle SW_F1 and SW_F2 in run mode → time is unaffected apart from normal ticking.
6. **Reset mid-set.** Drive RST low while in SET_MIN with time 7:42 PM → all outputs 0 asynchronously, SET_FIELD = 0. After RST high with TIMESET_RUN low → RUN, first SEC_TICK 4 cycles later.
